// File: rtl/pfb_pkg.sv
// Shared types and helpers for the PFB phase-compensation buffer.
//   bank_t      : which half of the ping-pong RAM
//   pc_state_t  : buffer FSM states
//   next_shift  : per-frame rotation advance, (s + D) mod M without pow2 wrap
//   rd_start    : first read index of a frame for a given shift and direction
package pfb_pkg;

  typedef enum logic {BANK_A = 1'b0, BANK_B = 1'b1} bank_t;
  typedef enum logic {PRIME = 1'b0, RUN = 1'b1} pc_state_t;

  // Compare-and-subtract keeps the result in 0..M-1 for any M.
  function automatic int next_shift(input int s, input int m, input int d);
    return (s >= m - d) ? s - (m - d) : s + d;
  endfunction

  // Descending reads start at (s-1) mod M, ascending reads at s.
  function automatic int rd_start(input int s, input int m, input bit reverse);
    if (!reverse) return s;
    return (s == 0) ? m - 1 : s - 1;
  endfunction

endpackage

// File: rtl/phasecomp_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Ports: clk, rst (sync, clears read register only), we/waddr/wdata,
//        re/raddr, rdata (valid 1 cycle after re; holds otherwise).
module phasecomp_sdp_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk)
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];

endmodule

// File: rtl/phasecomp_pingpong.sv
// Phase-compensation ping-pong buffer between polyphase FIR and FFT.
// Frames of M samples are written alternately into banks A/B; the previous
// frame is replayed circularly rotated by a shift advancing D mod M per frame.
// Ports: clk, rst (sync, active-high), din/din_valid (always accepted),
//        dout/dout_valid/dout_sof (1 cycle after the matching input),
//        shift (rotation of the frame currently being read).
module phasecomp_pingpong
  import pfb_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int M       = 8,
  parameter int D       = 6,
  parameter int REVERSE = 1,
  localparam int SW     = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_sof,
  output logic [SW-1:0]    shift
);

  localparam int AW = $clog2(2 * M);

  generate
    if (M < 2 || D <= 0 || D >= M) begin : g_bad_param
      $error("phasecomp_pingpong: need M >= 2 and 0 < D < M");
    end
  endgenerate

  pc_state_t        state, state_nx;
  bank_t            wbank;
  logic [SW-1:0]    wi, ri, ri_step, shift_r, shift_nx, start0, start_nx;
  logic             wrap, rd_en;
  logic [AW-1:0]    waddr, raddr;

  assign wrap     = din_valid && (wi == SW'(M - 1));
  assign shift_nx = SW'(next_shift(int'(shift_r), M, D));
  assign start0   = SW'(rd_start(0, M, REVERSE != 0));
  assign start_nx = SW'(rd_start(int'(shift_nx), M, REVERSE != 0));

  // Read index wraps inside the bank by compare, never by bit overflow.
  always_comb begin
    ri_step = ri;
    if (REVERSE != 0) ri_step = (ri == '0) ? SW'(M - 1) : ri - SW'(1);
    else              ri_step = (ri == SW'(M - 1)) ? '0 : ri + SW'(1);
  end

  // Reads always target the bank not being written.
  assign waddr = (wbank == BANK_B) ? AW'(M) + AW'(wi) : AW'(wi);
  assign raddr = (wbank == BANK_A) ? AW'(M) + AW'(ri) : AW'(ri);

  // FSM: state register
  always_ff @(posedge clk)
    if (rst) state <= PRIME;
    else     state <= state_nx;

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      PRIME:   if (wrap) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = PRIME;
    endcase
  end

  // FSM: outputs
  always_comb begin
    rd_en = 1'b0;
    if (state == RUN) rd_en = din_valid;
  end

  // Index counters, bank select, read shift
  always_ff @(posedge clk) begin
    if (rst) begin
      wi      <= '0;
      wbank   <= BANK_A;
      ri      <= '0;
      shift_r <= '0;
    end else if (din_valid) begin
      if (wrap) begin
        wi    <= '0;
        wbank <= (wbank == BANK_A) ? BANK_B : BANK_A;
        // Leaving PRIME the first stored frame is read with s_0 = 0.
        if (state == PRIME) begin
          shift_r <= '0;
          ri      <= start0;
        end else begin
          shift_r <= shift_nx;
          ri      <= start_nx;
        end
      end else begin
        wi <= wi + SW'(1);
        if (rd_en) ri <= ri_step;
      end
    end
  end

  // Output flags track the RAM read latency. wi is also the output index j
  // because each read is paired with one write of the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
    end else begin
      dout_valid <= rd_en;
      dout_sof   <= rd_en && (wi == '0);
    end
  end

  assign shift = shift_r;

  phasecomp_sdp_ram #(.WIDTH(WIDTH), .DEPTH(2 * M)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (din_valid),
    .waddr (waddr),
    .wdata (din),
    .re    (rd_en),
    .raddr (raddr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_phasecomp_pingpong.sv
module tb_phasecomp_pingpong;

  localparam int NC = 4;
  localparam int MS [NC] = '{8, 8, 12, 16};
  localparam int DS [NC] = '{6, 6, 9, 12};
  localparam int RS [NC] = '{1, 0, 1, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic [15:0] din = '0;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  generate
    for (genvar k = 0; k < NC; k++) begin : g
      localparam int MM  = MS[k];
      localparam int DD  = DS[k];
      localparam int RR  = RS[k];
      localparam int SWK = $clog2(MM);

      logic [15:0]    dout;
      logic           dv, sof;
      logic [SWK-1:0] sh;

      phasecomp_pingpong #(.WIDTH(16), .M(MM), .D(DD), .REVERSE(RR)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dv),
        .dout_sof   (sof),
        .shift      (sh)
      );

      // Reference model: frame k is read with shift (k*D) mod M.
      int wi_m, f_m, pd, last, s, j, idx;
      bit armed, pv, psof;
      int cur [MM];
      int prev [MM];

      initial begin
        wi_m = 0; f_m = 0; pd = 0; last = 0; armed = 0; pv = 0; psof = 0;
        forever begin
          @(negedge clk);
          if (armed) begin
            chk($sformatf("c%0d_valid", k), int'(dv), int'(pv));
            chk($sformatf("c%0d_dout", k), int'(dout), pv ? pd : last);
            chk($sformatf("c%0d_sof", k), int'(sof), pv ? int'(psof) : 0);
            if (pv) last = pd;
            chk($sformatf("c%0d_shift", k), int'(sh),
                (f_m >= 1) ? ((f_m - 1) * DD) % MM : 0);
          end
          pv = 0; psof = 0;
          if (rst) begin
            armed = 1; wi_m = 0; f_m = 0; last = 0;
          end else if (din_valid && armed) begin
            if (f_m >= 1) begin
              j   = wi_m;
              s   = ((f_m - 1) * DD) % MM;
              idx = (RR != 0) ? s - 1 - j : s + j;
              idx = ((idx % MM) + MM) % MM;
              pd = prev[idx]; pv = 1; psof = (j == 0);
            end
            cur[wi_m] = int'(din);
            wi_m++;
            if (wi_m == MM) begin
              prev = cur; wi_m = 0; f_m++;
            end
          end
        end
      end
    end
  endgenerate

  // Collectors for directed checks
  int q0[$];
  int q1[$];
  int sh1[$];
  int sh2[$];
  int sof3 = 0;

  initial forever begin
    @(negedge clk);
    if (g[0].dv)  q0.push_back(int'(g[0].dout));
    if (g[1].dv)  q1.push_back(int'(g[1].dout));
    if (g[1].sof) sh1.push_back(int'(g[1].sh));
    if (g[2].sof) sh2.push_back(int'(g[2].sh));
    if (g[3].sof) sof3++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v, input int gap_pct);
    while (int'($urandom_range(0, 99)) < gap_pct) begin
      din_valid = 1'b0; din = 16'hdead; step();
    end
    din = 16'(v); din_valid = 1'b1; step();
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; step(); step(); rst = 1'b0;
  endtask

  int t0 [24] = '{7, 6, 5, 4, 3, 2, 1, 0, 13, 12, 11, 10, 9, 8, 15, 14,
                  19, 18, 17, 16, 23, 22, 21, 20};
  int t1 [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 14, 15, 8, 9, 10, 11, 12, 13};
  int ts1 [5] = '{0, 6, 4, 2, 0};
  int ts2 [3] = '{0, 9, 6};

  initial begin
    // Contiguous 0..47: directed frames for M=8 both directions, M=12 shifts
    do_reset();
    q0.delete(); q1.delete(); sh1.delete(); sh2.delete();
    for (int i = 0; i < 48; i++) feed(i, 0);
    din_valid = 1'b0; step(); step();
    chk("a_q0_size", q0.size(), 40);
    for (int i = 0; i < 24; i++) chk($sformatf("a_rev_%0d", i), (i < q0.size()) ? q0[i] : -1, t0[i]);
    for (int i = 0; i < 16; i++) chk($sformatf("a_fwd_%0d", i), (i < q1.size()) ? q1[i] : -1, t1[i]);
    chk("a_sh1_size", sh1.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("a_sh1_%0d", i), (i < sh1.size()) ? sh1[i] : -1, ts1[i]);
    for (int i = 0; i < 3; i++) chk($sformatf("a_sh2_%0d", i), (i < sh2.size()) ? sh2[i] : -1, ts2[i]);

    // Same stream with random gaps must give the same output sequence
    do_reset();
    q0.delete();
    for (int i = 0; i < 32; i++) feed(i, 40);
    din_valid = 1'b0; step(); step();
    chk("b_q0_size", q0.size(), 24);
    for (int i = 0; i < 24; i++) chk($sformatf("b_rev_%0d", i), (i < q0.size()) ? q0[i] : -1, t0[i]);

    // Reset mid-frame after input 13, with din_valid high during reset
    do_reset();
    for (int i = 0; i < 14; i++) feed(i, 0);
    rst = 1'b1; din = 16'd999; din_valid = 1'b1; step();
    rst = 1'b0;
    q0.delete();
    for (int i = 0; i < 8; i++) feed(100 + i, 0);
    chk("c_prime_none", q0.size(), 0);
    feed(108, 0);
    din = 16'd109;
    @(negedge clk);
    chk("c_first_cnt", q0.size(), 1);
    chk("c_first_val", (q0.size() > 0) ? q0[0] : -1, 107);
    chk("c_first_shift", int'(g[0].sh), 0);
    @(posedge clk); #1;
    for (int i = 110; i < 116; i++) feed(i, 0);
    din_valid = 1'b0; step(); step();
    chk("c_q0_size", q0.size(), 8);

    // Soak: 1000 frames of M=16 with random stalls
    do_reset();
    sof3 = 0;
    for (int i = 0; i < 1000 * 16; i++) feed(int'($urandom_range(0, 65535)), 30);
    din_valid = 1'b0; step(); step(); step();
    chk("d_sof_count", sof3, 999);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
